mem_port_arbiter: RTL and testbench

- Shares the single external memory (SDRAM controller) port between three requesters: CPU mapper accesses, the ROM/config loader, and the SD image buffer.
- Sits between the mapper output (addr/rnw/ram_cs) and the SDRAM controller's req/ack interface.
- Serialises accesses through a small FSM and guarantees forward progress for the non-CPU requesters.

---
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single SDRAM controller port between CPU mapper accesses, the
// ROM/config loader and the SD image buffer, with bounded CPU preference.
//
// state | meaning
// IDLE  | arbitrate; winner's address/data registered, mem_req raised
// WAIT  | mem_* held stable until mem_ack
// DONE  | one-cycle ack/ready to the owner; levels may drop before next pick
module mem_port_arbiter #(
    parameter int ADDR_W     = 27,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rnw,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ready,
    output logic              cpu_overrun,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_din,
    output logic              ldr_ack,
    input  logic              sd_req,
    input  logic [ADDR_W-1:0] sd_addr,
    input  logic              sd_rnw,
    input  logic [7:0]        sd_din,
    output logic [7:0]        sd_dout,
    output logic              sd_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rnw,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ack,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_CPU  = 2'd1;
    localparam logic [1:0] G_LDR  = 2'd2;
    localparam logic [1:0] G_SD   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              cpu_pend;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_rnw;
    logic [7:0]        pend_din;
    logic [CNT_W-1:0]  cnt;

    logic              cpu_want;
    logic [ADDR_W-1:0] cpu_sel_addr;
    logic              cpu_sel_rnw;
    logic [7:0]        cpu_sel_din;
    logic              others;
    logic              starve;
    logic              pend_clr;
    logic              pend_load;
    logic [1:0]        win;

    // A strobe seen in IDLE competes immediately, using the live inputs.
    assign cpu_want     = cpu_pend | cpu_req;
    assign cpu_sel_addr = cpu_pend ? pend_addr : cpu_addr;
    assign cpu_sel_rnw  = cpu_pend ? pend_rnw  : cpu_rnw;
    assign cpu_sel_din  = cpu_pend ? pend_din  : cpu_din;

    assign others    = sd_req | ldr_req;
    assign starve    = others && (cnt == CNT_W'(STARVE_MAX));
    assign pend_clr  = (state == S_WAIT) && mem_ack && (grant == G_CPU);
    assign pend_load = cpu_req && (!cpu_pend || pend_clr);

    always_comb begin
        win = G_NONE;
        if (cpu_want && !starve) begin
            win = G_CPU;
        end else if (sd_req) begin
            win = G_SD;
        end else if (ldr_req) begin
            win = G_LDR;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win != G_NONE) state_nxt = S_WAIT;
            S_WAIT:  if (mem_ack) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_pend    <= 1'b0;
            pend_addr   <= '0;
            pend_rnw    <= 1'b0;
            pend_din    <= 8'd0;
            cpu_overrun <= 1'b0;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_rnw     <= 1'b0;
            mem_din     <= 8'd0;
            grant       <= G_NONE;
            cpu_dout    <= 8'd0;
            sd_dout     <= 8'd0;
            cpu_ready   <= 1'b0;
            ldr_ack     <= 1'b0;
            sd_ack      <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            ldr_ack   <= 1'b0;
            sd_ack    <= 1'b0;

            if (pend_load) begin
                cpu_pend  <= 1'b1;
                pend_addr <= cpu_addr;
                pend_rnw  <= cpu_rnw;
                pend_din  <= cpu_din;
            end else if (pend_clr) begin
                cpu_pend <= 1'b0;
            end
            if (cpu_req && cpu_pend && !pend_clr) begin
                cpu_overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (win != G_NONE) begin
                        mem_req <= 1'b1;
                        grant   <= win;
                    end
                    case (win)
                        G_CPU: begin
                            mem_addr <= cpu_sel_addr;
                            mem_rnw  <= cpu_sel_rnw;
                            mem_din  <= cpu_sel_din;
                            if (!others) begin
                                cnt <= '0;
                            end else if (cnt != CNT_W'(STARVE_MAX)) begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        G_SD: begin
                            mem_addr <= sd_addr;
                            mem_rnw  <= sd_rnw;
                            mem_din  <= sd_din;
                            cnt      <= '0;
                        end
                        G_LDR: begin
                            mem_addr <= ldr_addr;
                            mem_rnw  <= 1'b0;
                            mem_din  <= ldr_din;
                            cnt      <= '0;
                        end
                        default: ;
                    endcase
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        grant   <= G_NONE;
                        case (grant)
                            G_CPU: begin
                                cpu_ready <= 1'b1;
                                if (mem_rnw) cpu_dout <= mem_dout;
                            end
                            G_SD: begin
                                sd_ack <= 1'b1;
                                if (mem_rnw) sd_dout <= mem_dout;
                            end
                            G_LDR:   ldr_ack <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand sequences,
// with a grant scoreboard and a simple latency-programmable memory responder.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 27;
    localparam int STARVE_MAX = 8;
    localparam logic [1:0] G_CPU = 2'd1;
    localparam logic [1:0] G_LDR = 2'd2;
    localparam logic [1:0] G_SD  = 2'd3;

    logic              clk, reset;
    logic              cpu_req, cpu_rnw, cpu_ready, cpu_overrun;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din, cpu_dout;
    logic              ldr_req, ldr_ack;
    logic [ADDR_W-1:0] ldr_addr;
    logic [7:0]        ldr_din;
    logic              sd_req, sd_rnw, sd_ack;
    logic [ADDR_W-1:0] sd_addr;
    logic [7:0]        sd_din, sd_dout;
    logic              mem_req, mem_rnw, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din, mem_dout;
    logic [1:0]        grant;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ready(cpu_ready), .cpu_overrun(cpu_overrun),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_din(ldr_din), .ldr_ack(ldr_ack),
        .sd_req(sd_req), .sd_addr(sd_addr), .sd_rnw(sd_rnw), .sd_din(sd_din),
        .sd_dout(sd_dout), .sd_ack(sd_ack),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rnw(mem_rnw), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack), .grant(grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]        who;
        logic [ADDR_W-1:0] addr;
        logic              rnw;
        logic [7:0]        din;
    } xact_t;

    typedef struct {
        logic [1:0]        who;
        logic [ADDR_W-1:0] addr;
        logic              rnw;
        logic [7:0]        din;
        int                lat;
    } vec_t;

    xact_t      sb[$];
    xact_t      cur;
    bit         cur_valid;
    bit         prev_req;
    int         n_checks, n_fails, n_acks, lat_cnt, mem_lat;
    logic [7:0] exp_cpu_dout, exp_sd_dout;

    function automatic logic [7:0] model(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ {5'd0, a[26:24]} ^ 8'h83;
    endfunction

    function automatic logic [2:0] ack_of(input logic [1:0] who);
        case (who)
            G_CPU:   return 3'b001;
            G_LDR:   return 3'b010;
            G_SD:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    task automatic expect_x(input logic [1:0] who, input logic [ADDR_W-1:0] addr,
                            input logic rnw, input logic [7:0] din);
        xact_t x;
        x.who  = who;
        x.addr = addr;
        x.rnw  = rnw;
        x.din  = din;
        sb.push_back(x);
    endtask

    // One clock: monitor the DUT just after the edge, then drive the responder.
    task automatic step();
        logic [2:0] acks;
        @(posedge clk);
        #1;
        acks = {sd_ack, ldr_ack, cpu_ready};
        if (reset) begin
            cur_valid = 1'b0;
            prev_req  = 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                if (sb.size() == 0) begin
                    flag("unexpected_grant");
                end else begin
                    cur       = sb.pop_front();
                    cur_valid = 1'b1;
                    check("grant", 32'(grant), 32'(cur.who));
                    check("mem_addr", 32'(mem_addr), 32'(cur.addr));
                    check("mem_rnw", 32'(mem_rnw), 32'(cur.rnw));
                    if (!cur.rnw) check("mem_din", 32'(mem_din), 32'(cur.din));
                end
            end else if (mem_req && cur_valid) begin
                check("hold_addr", 32'(mem_addr), 32'(cur.addr));
                check("hold_grant", 32'(grant), 32'(cur.who));
            end
            if (acks != 3'b000) begin
                n_acks++;
                if (!cur_valid) begin
                    flag("stray_ack");
                end else begin
                    check("ack_vec", 32'(acks), 32'(ack_of(cur.who)));
                    check("grant_done", 32'(grant), 32'd0);
                    check("mem_req_done", 32'(mem_req), 32'd0);
                    if (cur.rnw && cur.who == G_CPU) exp_cpu_dout = model(cur.addr);
                    if (cur.rnw && cur.who == G_SD)  exp_sd_dout  = model(cur.addr);
                    check("cpu_dout", 32'(cpu_dout), 32'(exp_cpu_dout));
                    check("sd_dout", 32'(sd_dout), 32'(exp_sd_dout));
                    cur_valid = 1'b0;
                end
            end
            prev_req = mem_req;
        end
        mem_ack = 1'b0;
        if (!reset && mem_req) begin
            lat_cnt++;
            if (lat_cnt >= mem_lat) begin
                mem_ack  = 1'b1;
                mem_dout = model(mem_addr);
                lat_cnt  = 0;
            end
        end else begin
            lat_cnt = 0;
        end
    endtask

    task automatic wait_ack(input string name, input int budget);
        int a0;
        int c;
        a0 = n_acks;
        c  = 0;
        while (n_acks == a0 && c < budget) begin
            step();
            c++;
        end
        if (n_acks == a0) flag({name, "_timeout"});
    endtask

    task automatic cpu_strobe(input logic [ADDR_W-1:0] a, input logic rnw, input logic [7:0] d);
        cpu_addr = a;
        cpu_rnw  = rnw;
        cpu_din  = d;
        cpu_req  = 1'b1;
        step();
        cpu_req  = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        int   a0;
        int   cyc;

        tbl[0] = '{G_CPU, 27'h0000100, 1'b0, 8'h3C, 2};
        tbl[1] = '{G_SD,  27'h0ABCDEF, 1'b1, 8'h00, 3};
        tbl[2] = '{G_LDR, 27'h1000000, 1'b0, 8'h5A, 1};
        tbl[3] = '{G_CPU, 27'h7FFFFFF, 1'b1, 8'h00, 1};
        tbl[4] = '{G_SD,  27'h0000042, 1'b0, 8'hC3, 5};
        tbl[5] = '{G_CPU, 27'h0000000, 1'b1, 8'h00, 7};

        n_checks = 0; n_fails = 0; n_acks = 0; lat_cnt = 0; mem_lat = 4;
        cur_valid = 1'b0; prev_req = 1'b0;
        exp_cpu_dout = 8'd0; exp_sd_dout = 8'd0;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_addr = '0; cpu_rnw = 1'b0; cpu_din = 8'd0;
        ldr_req = 1'b0; ldr_addr = '0; ldr_din = 8'd0;
        sd_req = 1'b0; sd_addr = '0; sd_rnw = 1'b0; sd_din = 8'd0;
        mem_ack = 1'b0; mem_dout = 8'd0;

        step();
        step();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_ldr_ack", 32'(ldr_ack), 32'd0);
        check("rst_sd_ack", 32'(sd_ack), 32'd0);
        check("rst_overrun", 32'(cpu_overrun), 32'd0);
        check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        check("rst_sd_dout", 32'(sd_dout), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        reset = 1'b0;
        step();

        // Single CPU read, memory latency 4
        mem_lat = 4;
        expect_x(G_CPU, 27'h0001234, 1'b1, 8'h00);
        cpu_strobe(27'h0001234, 1'b1, 8'h00);
        check("t1_mem_req", 32'(mem_req), 32'd1);
        check("t1_mem_addr", 32'(mem_addr), 32'h0001234);
        a0 = n_acks;
        cyc = 0;
        while (n_acks == a0 && cyc < 20) begin
            step();
            cyc++;
        end
        check("t1_ready_delay", 32'(cyc), 32'd4);
        check("t1_cpu_dout", 32'(cpu_dout), 32'hA5);
        step();

        for (int i = 0; i < 6; i++) begin
            mem_lat = tbl[i].lat;
            expect_x(tbl[i].who, tbl[i].addr, (tbl[i].who == G_LDR) ? 1'b0 : tbl[i].rnw, tbl[i].din);
            case (tbl[i].who)
                G_CPU: cpu_strobe(tbl[i].addr, tbl[i].rnw, tbl[i].din);
                G_SD: begin
                    sd_addr = tbl[i].addr; sd_rnw = tbl[i].rnw; sd_din = tbl[i].din;
                    sd_req = 1'b1;
                end
                default: begin
                    ldr_addr = tbl[i].addr; ldr_din = tbl[i].din;
                    ldr_req = 1'b1;
                end
            endcase
            wait_ack("table", 30);
            sd_req  = 1'b0;
            ldr_req = 1'b0;
            step();
        end

        // Simultaneous requests: CPU, then SD, then LDR
        mem_lat = 3;
        expect_x(G_CPU, 27'h0000555, 1'b1, 8'h00);
        expect_x(G_SD,  27'h0000AAA, 1'b1, 8'h00);
        expect_x(G_LDR, 27'h0000777, 1'b0, 8'h99);
        sd_addr = 27'h0000AAA; sd_rnw = 1'b1; sd_din = 8'h00; sd_req = 1'b1;
        ldr_addr = 27'h0000777; ldr_din = 8'h99; ldr_req = 1'b1;
        cpu_strobe(27'h0000555, 1'b1, 8'h00);
        wait_ack("sim_cpu", 30);
        wait_ack("sim_sd", 30);
        sd_req = 1'b0;
        wait_ack("sim_ldr", 30);
        ldr_req = 1'b0;
        step();

        // Starvation: 8 CPU grants, loader, then CPU regains priority
        mem_lat = 2;
        for (int i = 0; i < 8; i++) expect_x(G_CPU, ADDR_W'(32'h100 + i), 1'b1, 8'h00);
        expect_x(G_LDR, 27'h0002000, 1'b0, 8'h77);
        expect_x(G_CPU, 27'h0000108, 1'b1, 8'h00);
        expect_x(G_CPU, 27'h0000109, 1'b1, 8'h00);
        expect_x(G_LDR, 27'h0002000, 1'b0, 8'h77);
        ldr_addr = 27'h0002000; ldr_din = 8'h77; ldr_req = 1'b1;
        cpu_strobe(27'h0000100, 1'b1, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            wait_ack("starve_cpu", 30);
            cpu_strobe(ADDR_W'(32'h100 + i), 1'b1, 8'h00);
        end
        wait_ack("starve_ldr", 30);
        wait_ack("resume_cpu", 30);
        cpu_strobe(27'h0000109, 1'b1, 8'h00);
        wait_ack("resume_cpu2", 30);
        wait_ack("resume_ldr", 30);
        ldr_req = 1'b0;
        step();

        // Overrun: two strobes while SD owns the port
        mem_lat = 6;
        expect_x(G_SD,  27'h0003000, 1'b0, 8'h11);
        expect_x(G_CPU, 27'h0004000, 1'b1, 8'h00);
        sd_addr = 27'h0003000; sd_rnw = 1'b0; sd_din = 8'h11; sd_req = 1'b1;
        step();
        cpu_strobe(27'h0004000, 1'b1, 8'h00);
        check("ovr_first", 32'(cpu_overrun), 32'd0);
        cpu_strobe(27'h0005000, 1'b1, 8'h00);
        check("ovr_set", 32'(cpu_overrun), 32'd1);
        wait_ack("ovr_sd", 30);
        sd_req = 1'b0;
        wait_ack("ovr_cpu", 30);
        repeat (6) step();
        check("ovr_sticky", 32'(cpu_overrun), 32'd1);

        // Withdrawn SD request and stray mem_ack in IDLE
        mem_lat = 8;
        expect_x(G_CPU, 27'h0006000, 1'b0, 8'hE1);
        cpu_strobe(27'h0006000, 1'b0, 8'hE1);
        sd_addr = 27'h0007000; sd_rnw = 1'b1; sd_req = 1'b1;
        step();
        step();
        sd_req = 1'b0;
        wait_ack("wd_cpu", 30);
        repeat (5) step();
        check("wd_idle_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b1;
        mem_dout = 8'hEE;
        step();
        check("stray_grant", 32'(grant), 32'd0);
        check("stray_mem_req", 32'(mem_req), 32'd0);
        check("stray_cpu_dout", 32'(cpu_dout), 32'(exp_cpu_dout));
        repeat (3) step();
        mem_lat = 2;
        expect_x(G_CPU, 27'h0006000, 1'b1, 8'h00);
        cpu_strobe(27'h0006000, 1'b1, 8'h00);
        wait_ack("stray_followup", 30);
        step();

        // Reset during WAIT with a CPU write outstanding
        mem_lat = 20;
        expect_x(G_CPU, 27'h0008000, 1'b0, 8'h42);
        cpu_strobe(27'h0008000, 1'b0, 8'h42);
        step();
        step();
        reset = 1'b1;
        step();
        check("rw_mem_req", 32'(mem_req), 32'd0);
        check("rw_grant", 32'(grant), 32'd0);
        check("rw_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rw_overrun", 32'(cpu_overrun), 32'd0);
        check("rw_cpu_dout", 32'(cpu_dout), 32'd0);
        reset = 1'b0;
        exp_cpu_dout = 8'd0;
        exp_sd_dout  = 8'd0;
        repeat (4) step();
        check("rw_idle_req", 32'(mem_req), 32'd0);
        mem_lat = 3;
        expect_x(G_CPU, 27'h0009000, 1'b1, 8'h00);
        cpu_strobe(27'h0009000, 1'b1, 8'h00);
        wait_ack("rw_followup", 30);
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
